// File: rtl/dds_sweep_ctrl_if.sv
// Control/config/status bundle between the register logic and dds_sweep_ctrl.
// The master drives the sweep configuration and the slave returns the FCW stream and status.
interface dds_sweep_ctrl_if #(
    parameter int unsigned N  = 10,
    parameter int unsigned DW = 16
);
    logic          start;
    logic          abort;
    logic          loop_en;
    logic [N-1:0]  start_fcw;
    logic [N-1:0]  stop_fcw;
    logic [N-1:0]  step_fcw;
    logic [DW-1:0] dwell;
    logic [N-1:0]  fcw;
    logic          fcw_valid;
    logic          phase_clr;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, loop_en, start_fcw, stop_fcw, step_fcw, dwell,
        input  fcw, fcw_valid, phase_clr, busy, done
    );

    modport slave (
        input  start, abort, loop_en, start_fcw, stop_fcw, step_fcw, dwell,
        output fcw, fcw_valid, phase_clr, busy, done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear FCW sweep sequencer for the DDS phase accumulator (sawtooth by default).
// Define SWEEP_BIDIR_EN for a triangle sweep that steps back down from stop to start.
module dds_sweep_ctrl #(
    parameter int unsigned N  = 10,
    parameter int unsigned DW = 16
) (
    input logic           clk,
    input logic           reset,
    dds_sweep_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StDwell, StStep, StDone} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [N-1:0]  start_q, start_d, stop_q, stop_d, step_q, step_d;
    logic          loop_q, loop_d;
    logic [N-1:0]  fcw_q, fcw_d;
    logic          valid_q, valid_d, clr_q, clr_d, busy_q, busy_d, done_q, done_d;

    logic [DW-1:0] dwell_eff;
    logic [N:0]    sum;
    logic [N-1:0]  up_fcw, next_fcw, wrap_fcw;
    logic          degenerate, sweep_end;

    assign dwell_eff  = (bus.dwell == '0) ? DW'(1) : bus.dwell;
    assign degenerate = (step_q == '0) || (start_q > stop_q);
    // Widened add so an overflow past 2^N still clamps to stop.
    assign sum        = {1'b0, fcw_q} + {1'b0, step_q};
    assign up_fcw     = (sum > {1'b0, stop_q}) ? stop_q : sum[N-1:0];

`ifdef SWEEP_BIDIR_EN
    logic          dir_q, dir_d;  // 1 = stepping down
    logic [N:0]    diff;
    logic [N-1:0]  down_fcw;
    logic          turn;

    assign diff      = {1'b0, fcw_q} - {1'b0, step_q};
    assign down_fcw  = (diff[N] || (diff[N-1:0] < start_q)) ? start_q : diff[N-1:0];
    assign sweep_end = degenerate || (start_q == stop_q) || (dir_q && (fcw_q == start_q));
    assign turn      = !dir_q && (fcw_q == stop_q);
    assign next_fcw  = (dir_q || turn) ? down_fcw : up_fcw;
    // Looping from the bottom goes straight back up so start is not emitted twice.
    assign wrap_fcw  = degenerate ? start_q : up_fcw;
`else
    assign sweep_end = degenerate || (fcw_q == stop_q);
    assign next_fcw  = up_fcw;
    assign wrap_fcw  = start_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dwell_q <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            loop_q  <= 1'b0;
            fcw_q   <= '0;
            valid_q <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SWEEP_BIDIR_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            loop_q  <= loop_d;
            fcw_q   <= fcw_d;
            valid_q <= valid_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SWEEP_BIDIR_EN
            dir_q   <= dir_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: if (bus.start) state_d = StDwell;
                StDwell:        if (cnt_q == DW'(1)) state_d = StStep;
                StStep:         state_d = (sweep_end && !loop_q) ? StDone : StDwell;
                default:        state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        loop_d  = loop_q;
        fcw_d   = fcw_q;
        valid_d = 1'b0;
        clr_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SWEEP_BIDIR_EN
        dir_d   = dir_q;
`endif
        if (bus.abort) begin
            busy_d = 1'b0;
`ifdef SWEEP_BIDIR_EN
            dir_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        dwell_d = dwell_eff;
                        start_d = bus.start_fcw;
                        stop_d  = bus.stop_fcw;
                        step_d  = bus.step_fcw;
                        loop_d  = bus.loop_en;
                        fcw_d   = bus.start_fcw;
                        cnt_d   = dwell_eff;
                        valid_d = 1'b1;
                        clr_d   = 1'b1;
                        busy_d  = 1'b1;
`ifdef SWEEP_BIDIR_EN
                        dir_d   = 1'b0;
`endif
                    end
                end
                StDwell: if (cnt_q != DW'(1)) cnt_d = cnt_q - DW'(1);
                StStep: begin
                    if (sweep_end && !loop_q) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        fcw_d   = sweep_end ? wrap_fcw : next_fcw;
                        valid_d = 1'b1;
                        cnt_d   = dwell_q;
`ifdef SWEEP_BIDIR_EN
                        dir_d   = sweep_end ? 1'b0 : (dir_q | turn);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fcw       = fcw_q;
    assign bus.fcw_valid = valid_q;
    assign bus.phase_clr = clr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed cases plus randomized sweeps compared
// cycle by cycle against a trace built from the sweep's value list and hold time.
module tb_dds_sweep_ctrl;
    localparam int N  = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dds_sweep_ctrl_if #(.N(N), .DW(DW)) bus ();
    dds_sweep_ctrl #(.N(N), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    int pass_q[$];
    logic [N+3:0] exp_q[$];

    function automatic logic [N+3:0] pack(int f, bit v, bit c, bit b, bit d);
        logic [N-1:0] fv;
        fv = f[N-1:0];
        return {fv, v, c, b, d};
    endfunction

    task automatic check(input string tag, input logic [N+3:0] exp);
        logic [N+3:0] obs;
        obs = {bus.fcw, bus.fcw_valid, bus.phase_clr, bus.busy, bus.done};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed fcw=%0d vld/clr/busy/done=%b, expected fcw=%0d vld/clr/busy/done=%b",
                   tag, obs[N+3:4], obs[3:0], exp[N+3:4], exp[3:0]);
        end
    endtask

    // One pass of FCW values as the sweep rules define them.
    task automatic gen_pass(input int s, input int e, input int st);
        int v;
        pass_q.delete();
        pass_q.push_back(s);
        if (st == 0 || s > e) return;
        v = s;
        while (v != e) begin
            v = (v + st > e) ? e : v + st;
            pass_q.push_back(v);
        end
`ifdef SWEEP_BIDIR_EN
        while (v != s) begin
            v = (v - st < s) ? s : v - st;
            pass_q.push_back(v);
        end
`endif
    endtask

    // Expected per-cycle outputs, starting the cycle after start is sampled.
    task automatic build_trace(input int s, input int e, input int st, input int d,
                               input bit lp, input int ncyc);
        int hold, first_idx, last;
        bit first;
        hold = ((d == 0) ? 1 : d) + 1;
        gen_pass(s, e, st);
        exp_q.delete();
        first = 1'b1;
        if (!lp) begin
            foreach (pass_q[i])
                for (int h = 0; h < hold; h++)
                    exp_q.push_back(pack(pass_q[i], h == 0, (i == 0) && (h == 0), 1'b1, 1'b0));
            last = pass_q[pass_q.size()-1];
            exp_q.push_back(pack(last, 1'b0, 1'b0, 1'b0, 1'b1));
            exp_q.push_back(pack(last, 1'b0, 1'b0, 1'b0, 1'b0));
        end else begin
            while (exp_q.size() < ncyc) begin
`ifdef SWEEP_BIDIR_EN
                first_idx = (first || pass_q.size() == 1) ? 0 : 1;
`else
                first_idx = 0;
`endif
                for (int i = first_idx; i < pass_q.size(); i++)
                    for (int h = 0; h < hold; h++)
                        exp_q.push_back(pack(pass_q[i], h == 0, first && (i == 0) && (h == 0),
                                             1'b1, 1'b0));
                first = 1'b0;
            end
        end
    endtask

    // cut_kind: 0 = abort+start together, 1 = synchronous reset.
    task automatic run_case(input string tag, input int s, input int e, input int st,
                            input int d, input bit lp, input int cut_at, input int cut_kind);
        logic [N+3:0] cur;
        @(negedge clk);
        bus.start_fcw = s[N-1:0];
        bus.stop_fcw  = e[N-1:0];
        bus.step_fcw  = st[N-1:0];
        bus.dwell     = d[DW-1:0];
        bus.loop_en   = lp;
        bus.abort     = 1'b0;
        bus.start     = 1'b1;
        build_trace(s, e, st, d, lp, cut_at + 1);
        @(negedge clk);
        bus.start = 1'b0;
        // Scramble config to show it was latched at start.
        bus.start_fcw = N'($urandom);
        bus.stop_fcw  = N'($urandom);
        bus.step_fcw  = N'($urandom);
        bus.dwell     = DW'($urandom_range(0, 7));
        bus.loop_en   = ~lp;
        for (int j = 0; j < exp_q.size(); j++) begin
            check(tag, exp_q[j]);
            if (j == cut_at) begin
                cur = exp_q[j];
                if (cut_kind == 0) begin
                    bus.abort = 1'b1;
                    bus.start = 1'b1;
                    @(negedge clk);
                    bus.abort = 1'b0;
                    bus.start = 1'b0;
                    check({tag, "_abort"}, {cur[N+3:4], 4'b0000});
                    @(negedge clk);
                    check({tag, "_idle"}, {cur[N+3:4], 4'b0000});
                end else begin
                    reset = 1'b0;
                    @(negedge clk);
                    reset = 1'b1;
                    check({tag, "_rst"}, '0);
                    @(negedge clk);
                    check({tag, "_rst_idle"}, '0);
                end
                break;
            end
            // Start while busy must be ignored.
            bus.start = exp_q[j][1] && ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int s, e, st, d, cut, kind;
        bit lp;
        bus.start = 1'b0; bus.abort = 1'b0; bus.loop_en = 1'b0;
        bus.start_fcw = '0; bus.stop_fcw = '0; bus.step_fcw = '0; bus.dwell = '0;
        reset = 1'b0;
        @(negedge clk);
        check("reset0", '0);
        @(negedge clk);
        check("reset1", '0);
        reset = 1'b1;
        @(negedge clk);
        check("idle", '0);

        run_case("single",  100, 130, 10, 3, 1'b0, -1, 0);
        run_case("clamp",  1000, 1020, 15, 1, 1'b0, -1, 0);
        run_case("loop",      0,   20, 10, 2, 1'b1, 40, 0);
        run_case("abort110", 100, 130, 10, 3, 1'b0, 5, 0);
        run_case("step0",    50,   60,  0, 0, 1'b0, -1, 0);
        run_case("rev",      70,   40,  5, 1, 1'b0, -1, 0);
        run_case("bidir",     0,   20, 10, 1, 1'b0, -1, 0);
        run_case("midreset", 200, 300, 25, 2, 1'b0, 9, 1);
        run_case("restart",  1020, 1023, 2, 0, 1'b0, -1, 0);

        for (int r = 0; r < 24; r++) begin
            s  = $urandom_range(0, 1023);
            e  = s + $urandom_range(0, 200);
            if (e > 1023) e = 1023;
            if ($urandom_range(0, 7) == 0 && s > 0) e = $urandom_range(0, s - 1);
            st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(3, 60);
            d  = $urandom_range(0, 4);
            lp = ($urandom_range(0, 2) == 0);
            cut  = lp ? $urandom_range(0, 120) : $urandom_range(0, 400);
            kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_case("rand", s, e, st, d, lp, cut, kind);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS core. It drives the N-bit frequency control word (FCW, the phase increment) of the phase accumulator through a programmed linear sweep: start value, step, stop value, and a dwell time per step. It can run a single pass or loop continuously, and it requests a phase-accumulator clear at sweep start. It sits between the register/config logic and the `main` DDS instance.

## Interface
- `N`, 10: FCW / phase-accumulator width; matches the DDS core.
- `DW`, 16: dwell counter width.

- `clk`, in, 1: system clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge).
- `start`, in, 1: level-sampled sweep start request.
- `abort`, in, 1: stop the sweep immediately.
- `loop_en`, in, 1: 1 = restart the sweep at the end; 0 = single pass.
- `start_fcw`, in, N: first FCW.
- `stop_fcw`, in, N: final FCW.
- `step_fcw`, in, N: FCW increment per step.
- `dwell`, in, DW: cycles each FCW is held; 0 is treated as 1.
- `fcw`, out, N: FCW to the DDS.
- `fcw_valid`, out, 1: 1-cycle pulse whenever `fcw` takes a new value.
- `phase_clr`, out, 1: 1-cycle pulse requesting an accumulator clear.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: 1-cycle pulse at the end of a single-pass sweep.

## Operation
- States: IDLE, DWELL, STEP, DONE.
- Config inputs (`start_fcw`, `stop_fcw`, `step_fcw`, `dwell`, `loop_en`) are latched when `start` is accepted. Later changes have no effect until the next start.
- **IDLE/DONE**, `start`=1, `abort`=0:
  - latch config; `fcw`←`start_fcw`; pulse `fcw_valid` and `phase_clr`; `busy`←1.
  - load dwell counter with max(`dwell`,1); go to DWELL.
- **DWELL**: decrement the counter each cycle. When it reaches 1, go to STEP.
- **STEP**, end test:
  - end-of-sweep when `fcw`==stop, or `step_fcw`==0, or `start_fcw`>`stop_fcw`.
  - if end-of-sweep and loop: `fcw`←start, pulse `fcw_valid` only (no `phase_clr`), reload the counter, go to DWELL.
  - if end-of-sweep and no loop: pulse `done`, `busy`←0, go to DONE. `fcw` holds its last value.
- **STEP**, otherwise:
  - `fcw`←min(`fcw`+`step_fcw`, stop), computed at N+1 bits so overflow clamps to stop.
  - pulse `fcw_valid`, reload the counter, go to DWELL.
- STEP lasts one cycle. Each FCW is held for max(`dwell`,1)+1 cycles, including the STEP cycle. The first FCW is held the same length.
- **DONE**: identical to IDLE except for its state encoding; `start` restarts the sweep.
- `abort`=1 in any state: next cycle go to IDLE, `busy`←0, no `done` pulse, `fcw` holds.
  - `abort` wins over a simultaneous `start`.
- `start` while busy is ignored.
- `reset` mid-sweep: all state is cleared next edge, with no `done` pulse.

## Timing
- Reset values: `fcw`=0, `fcw_valid`=0, `phase_clr`=0, `busy`=0, `done`=0; state IDLE.
- All outputs are registered.
- Start latency: `start` is sampled high at edge k; `fcw`, `fcw_valid`, `phase_clr` and `busy` are updated after edge k.
- Every FCW change coincides with exactly one `fcw_valid` cycle.
- The DDS applies `fcw` on the cycle after `fcw_valid`.
- In single-pass mode, `done` and `busy` falling occur in the same cycle.

## Configuration
- `SWEEP_BIDIR_EN` defined: triangle sweep.
  - On reaching stop, the direction flips and the block steps down: `fcw`←max(`fcw`−step, start), computed at N+1 bits so underflow clamps to start.
  - The stop value is emitted once at the turnaround, not twice.
  - On reaching start going down: loop flips up again; single pass pulses `done`.
  - The direction register resets to up on reset, start, and abort.
- `SWEEP_BIDIR_EN` undefined: sawtooth only, as described under Operation; no direction register.

## Test plan
- **Single pass.** Reset low for 2 cycles, then start with start=100, stop=130, step=10, dwell=3, loop=0.
  - Required: `fcw` sequence 100,110,120,130, each held 4 cycles.
  - 4 `fcw_valid` pulses, 1 `phase_clr` pulse.
  - `done` pulses one cycle after 130's 4 cycles end; then `busy`=0.
- **Clamp.** start=1000, stop=1020, step=15, dwell=1.
  - Required: `fcw` sequence 1000,1015,1020, then `done`; no wrap past 1023.
- **Loop.** start=0, stop=20, step=10, dwell=2, loop=1.
  - Required: `fcw` sequence 0,10,20,0,10,…, never `done`.
  - `phase_clr` only at the first 0.
- **Abort.** Assert `abort`+`start` in the same cycle mid-sweep with `fcw`=110.
  - Required: next cycle `busy`=0, `fcw`=110, no `done`, state IDLE.
- **Degenerate cases.**
  - step=0, start=50, stop=60, dwell=0 → `fcw`=50 for 2 cycles, then `done`.
  - `start` pulse while busy is ignored.
- **SWEEP_BIDIR_EN, loop=0.** start=0, stop=20, step=10, dwell=1.
  - Required: `fcw` sequence 0,10,20,10,0, then `done`.
